// File: rtl/lpc_pkg.sv
// Shared constants, header layout and state encoding for the LPC frame encoder.
package lpc_pkg;

  localparam int HDR_W         = 8;
  localparam int HDR_MODE_BIT  = 7;
  localparam int HDR_SHORT_BIT = 6;
  localparam int HDR_CNT_LSB   = 0;
  localparam int HDR_CNT_W     = 6;

  localparam logic MODE_ORD1 = 1'b0;
  localparam logic MODE_ORD2 = 1'b1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [HDR_W-1:0] make_hdr(input logic                 mode,
                                                input logic                 short_f,
                                                input logic [HDR_CNT_W-1:0] cnt);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_MODE_BIT]                = mode;
    h[HDR_SHORT_BIT]               = short_f;
    h[HDR_CNT_LSB +: HDR_CNT_W]    = cnt;
    return h;
  endfunction

endpackage

// File: rtl/lpc_residual.sv
// Combinational order-1 / order-2 fixed-predictor residual.
module lpc_residual
  import lpc_pkg::*;
#(
  parameter  int SAMPLE_W = 16,
  localparam int RES_W    = SAMPLE_W + 2
) (
  input  logic signed [SAMPLE_W-1:0] x_i,
  input  logic signed [SAMPLE_W-1:0] x1_i,
  input  logic signed [SAMPLE_W-1:0] x2_i,
  input  logic                       mode_i,
  output logic signed [RES_W-1:0]    e_o
);

  logic signed [RES_W-1:0] xe, x1e, x2e;

  // Two guard bits make x - 2*x1 + x2 exact over the full input range.
  assign xe  = {{2{x_i[SAMPLE_W-1]}},  x_i};
  assign x1e = {{2{x1_i[SAMPLE_W-1]}}, x1_i};
  assign x2e = {{2{x2_i[SAMPLE_W-1]}}, x2_i};

  always_comb begin
    if (mode_i == MODE_ORD2) begin
      e_o = xe - x1e - x1e + x2e;
    end else begin
      e_o = xe - x1e;
    end
  end

endmodule

// File: rtl/lpc_frame_encoder.sv
// Packs per-sample LPC residuals into fixed-width frames with a header and
// a one-frame park slot for downstream backpressure.
module lpc_frame_encoder
  import lpc_pkg::*;
#(
  parameter  int SAMPLE_W  = 16,
  parameter  int FRAME_LEN = 4,
  localparam int RES_W     = SAMPLE_W + 2,
  localparam int OUT_W     = HDR_W + FRAME_LEN * RES_W
) (
  input  logic                       ACLK,
  input  logic                       ARESET_N,
  input  logic signed [SAMPLE_W-1:0] IN_SOURCE,
  input  logic                       IN_VALID,
  input  logic                       T_LAST,
  input  logic                       MODE,
  output logic                       READY,
  output logic                       OUT_VALID,
  output logic                       OUT_LAST,
  output logic [OUT_W-1:0]           OUT_CODED,
  input  logic                       T_READY,
  output logic [15:0]                FRAME_CNT
);

  localparam int                   BUF_W = FRAME_LEN * RES_W;
  localparam logic [HDR_CNT_W-1:0] LenC  = HDR_CNT_W'(FRAME_LEN);

  state_e                      state_q, state_d;
  logic                        rdy_en_q;
  logic [HDR_CNT_W-1:0]        cnt_q, cnt_d;
  logic                        mode_q, mode_d;
  logic signed [SAMPLE_W-1:0]  h1_q, h1_d, h2_q, h2_d;
  logic [BUF_W-1:0]            buf_q, buf_d;
  logic                        park_last_q, park_last_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [OUT_W-1:0]            out_coded_q, out_coded_d;
  logic [15:0]                 frame_cnt_q, frame_cnt_d;

  logic                        ready;
  logic                        accept;
  logic                        out_free;
  logic                        close;
  logic                        mode_eff;
  logic [HDR_CNT_W-1:0]        cnt_inc;
  logic signed [RES_W-1:0]     res;
  logic [BUF_W-1:0]            buf_ins;

  // rdy_en_q keeps READY low until the first clock edge after reset release.
  assign ready    = rdy_en_q && (state_q == FILL);
  assign accept   = IN_VALID && ready;
  assign out_free = !out_valid_q || T_READY;
  assign mode_eff = (cnt_q == '0) ? MODE : mode_q;
  assign cnt_inc  = cnt_q + HDR_CNT_W'(1);
  assign close    = accept && (T_LAST || (cnt_inc == LenC));

  lpc_residual #(
    .SAMPLE_W (SAMPLE_W)
  ) u_residual (
    .x_i    (IN_SOURCE),
    .x1_i   (h1_q),
    .x2_i   (h2_q),
    .mode_i (mode_eff),
    .e_o    (res)
  );

  always_comb begin
    buf_ins = buf_q;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (cnt_q == HDR_CNT_W'(k)) begin
        buf_ins[k*RES_W +: RES_W] = res;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    buf_d       = buf_q;
    park_last_d = park_last_q;
    out_valid_d = out_valid_q && !T_READY;
    out_last_d  = out_last_q;
    out_coded_d = out_coded_q;
    frame_cnt_d = frame_cnt_q;

    if (out_valid_q && T_READY) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          mode_d = mode_eff;
          h2_d   = h1_q;
          h1_d   = IN_SOURCE;
          cnt_d  = cnt_inc;
          buf_d  = buf_ins;
          if (close) begin
            h1_d = '0;
            h2_d = '0;
            if (out_free) begin
              out_valid_d = 1'b1;
              out_last_d  = T_LAST;
              out_coded_d = {make_hdr(mode_eff, cnt_inc != LenC, cnt_inc), buf_ins};
              cnt_d       = '0;
              buf_d       = '0;
            end else begin
              // Completed frame stays in buf_q/cnt_q/mode_q until the output frees.
              park_last_d = T_LAST;
              state_d     = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_last_d  = park_last_q;
          out_coded_d = {make_hdr(mode_q, cnt_q != LenC, cnt_q), buf_q};
          cnt_d       = '0;
          buf_d       = '0;
          park_last_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state_q     <= FILL;
      rdy_en_q    <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      h1_q        <= '0;
      h2_q        <= '0;
      buf_q       <= '0;
      park_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_coded_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      buf_q       <= buf_d;
      park_last_q <= park_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_coded_q <= out_coded_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign READY     = ready;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_CODED = out_coded_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule
